ordered_write_commit: RTL and testbench

//   Sits directly upstream of a variable/net driver stage. It accepts a burst of

---
 rtl/ordered_write_commit_pkg.sv | 12 +
 rtl/ordered_write_commit_wc_fifo.sv | 78 +++++++
 rtl/ordered_write_commit.sv | 105 ++++++++++
 tb/tb_ordered_write_commit.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/ordered_write_commit_pkg.sv
// Shared types and helpers for the ordered write-commit block and its queue.
package ordered_write_pkg;

    typedef logic [15:0] cnt16_t;

    localparam cnt16_t CNT_MAX = 16'hFFFF;

    function automatic int ptr_w(input int depth);
        return (depth > 32'sd1) ? $clog2(depth) : 32'sd1;
    endfunction

endpackage

// File: rtl/ordered_write_commit_wc_fifo.sv
// Circular buffer with push, pop and in-place tail overwrite; no accept policy here.
module wc_fifo
    import ordered_write_pkg::*;
#(
    parameter int WIDTH = 1,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       i_push,
    input  logic                       i_pop,
    input  logic                       i_ovr,
    input  logic [WIDTH-1:0]           i_data,
    output logic [WIDTH-1:0]           o_head,
    output logic [ptr_w(DEPTH):0]      o_count,
    output logic                       o_empty,
    output logic                       o_full
);

    localparam int             PW       = ptr_w(DEPTH);
    localparam logic [PW:0]    FULL_CNT = (PW+1)'(DEPTH);
    localparam logic [PW:0]    ZERO_CNT = {(PW+1){1'b0}};

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic [PW:0]      r_count;

    logic             w_do_push;
    logic             w_do_pop;
    logic             w_do_ovr;
    logic [PW-1:0]    w_tail_ptr;

    assign w_do_push  = i_push && (r_count != FULL_CNT);
    assign w_do_pop   = i_pop && (r_count != ZERO_CNT);
    assign w_do_ovr   = i_ovr && !i_push && (r_count != ZERO_CNT);
    assign w_tail_ptr = r_wr_ptr - PW'(1);

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= {PW{1'b0}};
            r_rd_ptr <= {PW{1'b0}};
            r_count  <= ZERO_CNT;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + PW'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + (PW+1)'(1);
                2'b01:   r_count <= r_count - (PW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Entry storage; overwrite targets the most recently pushed slot.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= {WIDTH{1'b0}};
            end
        end else if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end else if (w_do_ovr) begin
            r_mem[w_tail_ptr] <= i_data;
        end
    end

    assign o_head  = r_mem[r_rd_ptr];
    assign o_count = r_count;
    assign o_empty = (r_count == ZERO_CNT);
    assign o_full  = (r_count == FULL_CNT);

endmodule

// File: rtl/ordered_write_commit.sv
// Commits queued writes to out_q strictly in program order, one per cycle,
// with optional coalescing of pending writes into the tail entry.
module ordered_write_commit
    import ordered_write_pkg::*;
#(
    parameter int               WIDTH     = 1,
    parameter int               DEPTH     = 4,
    parameter int               COALESCE  = 0,
    parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}}
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_valid,
    input  logic [WIDTH-1:0]  wr_data,
    output logic              wr_ready,
    input  logic              commit_ready,
    output logic [WIDTH-1:0]  out_q,
    output logic              out_commit,
    output logic              settled,
    output cnt16_t            commit_count,
    output cnt16_t            coalesce_count
);

    localparam int          PW      = ptr_w(DEPTH);
    localparam logic [PW:0] CNT_TWO = (PW+1)'(2);
    localparam bit          COAL_EN = (COALESCE != 32'sd0);

    logic [WIDTH-1:0] w_head;
    logic [PW:0]      w_count;
    logic             w_empty;
    logic             w_full;
    logic             w_wr_ready;
    logic             w_accept;
    logic             w_pop;
    logic             w_push;
    logic             w_ovr;

    logic [WIDTH-1:0] r_out_q;
    logic             r_out_commit;
    cnt16_t           r_commit_count;
    cnt16_t           r_coalesce_count;

    wc_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_ovr   (w_ovr),
        .i_data  (wr_data),
        .o_head  (w_head),
        .o_count (w_count),
        .o_empty (w_empty),
        .o_full  (w_full)
    );

    // Ready depends only on registered occupancy, never on commit_ready.
    assign w_wr_ready = COAL_EN ? 1'b1 : !w_full;
    assign w_accept   = wr_valid && w_wr_ready;
    assign w_pop      = !w_empty && commit_ready;

    // Push vs overwrite; a lone entry leaving this cycle must not be clobbered.
    always_comb begin
        w_push = 1'b0;
        w_ovr  = 1'b0;
        if (!w_accept) begin
            w_push = 1'b0;
        end else if (!COAL_EN || w_empty) begin
            w_push = 1'b1;
        end else if ((w_count >= CNT_TWO) || !w_pop) begin
            w_ovr = 1'b1;
        end else begin
            w_push = 1'b1;
        end
    end

    // Commit register, commit pulse and event counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_q          <= RESET_VAL;
            r_out_commit     <= 1'b0;
            r_commit_count   <= 16'h0000;
            r_coalesce_count <= 16'h0000;
        end else begin
            r_out_commit <= w_pop;
            if (w_pop) begin
                r_out_q        <= w_head;
                r_commit_count <= r_commit_count + 16'h0001;
            end
            if (w_ovr && (r_coalesce_count != CNT_MAX)) begin
                r_coalesce_count <= r_coalesce_count + 16'h0001;
            end
        end
    end

    assign wr_ready       = w_wr_ready;
    assign out_q          = r_out_q;
    assign out_commit     = r_out_commit;
    assign settled        = w_empty;
    assign commit_count   = r_commit_count;
    assign coalesce_count = r_coalesce_count;

endmodule

// File: tb/tb_ordered_write_commit.sv
// Directed bench: a non-coalescing and a coalescing instance share stimulus and
// are checked every cycle against a list-based model, plus literal spot checks.
module tb_ordered_write_commit;

    localparam logic [7:0] RV_NC = 8'hA5;
    localparam logic [7:0] RV_CO = 8'h00;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        wr_valid = 1'b0;
    logic [7:0]  wr_data = 8'h00;
    logic        commit_ready = 1'b0;

    logic        nc_ready, nc_pulse, nc_settled;
    logic [7:0]  nc_q;
    logic [15:0] nc_cc, nc_coal;
    logic        co_ready, co_pulse, co_settled;
    logic [7:0]  co_q;
    logic [15:0] co_cc, co_coal;

    int n_checks = 0;
    int n_err    = 0;

    ordered_write_commit #(.WIDTH(8), .DEPTH(4), .COALESCE(0), .RESET_VAL(RV_NC)) u_nc (
        .clk(clk), .rst(rst), .wr_valid(wr_valid), .wr_data(wr_data), .wr_ready(nc_ready),
        .commit_ready(commit_ready), .out_q(nc_q), .out_commit(nc_pulse), .settled(nc_settled),
        .commit_count(nc_cc), .coalesce_count(nc_coal));

    ordered_write_commit #(.WIDTH(8), .DEPTH(4), .COALESCE(1), .RESET_VAL(RV_CO)) u_co (
        .clk(clk), .rst(rst), .wr_valid(wr_valid), .wr_data(wr_data), .wr_ready(co_ready),
        .commit_ready(commit_ready), .out_q(co_q), .out_commit(co_pulse), .settled(co_settled),
        .commit_count(co_cc), .coalesce_count(co_coal));

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    // Model: index 0 = non-coalescing, 1 = coalescing. Pending writes kept as an ordered list.
    logic [7:0]  mq [2][4];
    int          msz [2];
    logic [7:0]  mout [2];
    logic        mpulse [2];
    logic [15:0] mcc [2];
    logic [15:0] mcoal [2];
    int          m_n;
    bit          m_pop, m_acc, m_rdy;

    function automatic bit exp_ready(input int k);
        return (k == 1) ? 1'b1 : (msz[k] < 4);
    endfunction

    initial begin
        forever begin
            @(posedge clk or posedge rst);
            for (int k = 0; k < 2; k++) begin
                if (rst) begin
                    msz[k]    = 0;
                    mout[k]   = (k == 0) ? RV_NC : RV_CO;
                    mpulse[k] = 1'b0;
                    mcc[k]    = 16'h0000;
                    mcoal[k]  = 16'h0000;
                end else begin
                    m_n   = msz[k];
                    m_rdy = exp_ready(k);
                    m_acc = wr_valid && m_rdy;
                    m_pop = (m_n > 0) && commit_ready;
                    mpulse[k] = m_pop;
                    if (m_pop) begin
                        mout[k] = mq[k][0];
                        for (int i = 0; i < 3; i++) mq[k][i] = mq[k][i+1];
                        msz[k]--;
                        mcc[k] = mcc[k] + 16'h0001;
                    end
                    if (m_acc) begin
                        if (k == 1 && (m_n >= 2 || (m_n == 1 && !m_pop))) begin
                            mq[k][msz[k]-1] = wr_data;
                            if (mcoal[k] != 16'hFFFF) mcoal[k] = mcoal[k] + 16'h0001;
                        end else begin
                            mq[k][msz[k]] = wr_data;
                            msz[k]++;
                        end
                    end
                end
            end
            #1;
            chk("nc.out_q",      {24'h0, nc_q},       {24'h0, mout[0]});
            chk("nc.out_commit", {31'h0, nc_pulse},   {31'h0, mpulse[0]});
            chk("nc.settled",    {31'h0, nc_settled}, {31'h0, (msz[0] == 0)});
            chk("nc.wr_ready",   {31'h0, nc_ready},   {31'h0, exp_ready(0)});
            chk("nc.commit_cnt", {16'h0, nc_cc},      {16'h0, mcc[0]});
            chk("nc.coal_cnt",   {16'h0, nc_coal},    {16'h0, mcoal[0]});
            chk("co.out_q",      {24'h0, co_q},       {24'h0, mout[1]});
            chk("co.out_commit", {31'h0, co_pulse},   {31'h0, mpulse[1]});
            chk("co.settled",    {31'h0, co_settled}, {31'h0, (msz[1] == 0)});
            chk("co.wr_ready",   {31'h0, co_ready},   {31'h0, exp_ready(1)});
            chk("co.commit_cnt", {16'h0, co_cc},      {16'h0, mcc[1]});
            chk("co.coal_cnt",   {16'h0, co_coal},    {16'h0, mcoal[1]});
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic drive(input logic v, input logic [7:0] d, input logic cr);
        wr_valid     = v;
        wr_data      = d;
        commit_ready = cr;
    endtask

    task automatic do_reset();
        drive(1'b0, 8'h00, 1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        tick();
        tick();
        chk("lit.reset nc.out_q",   {24'h0, nc_q},       32'hA5);
        chk("lit.reset co.out_q",   {24'h0, co_q},       32'h00);
        chk("lit.reset nc.settled", {31'h0, nc_settled}, 32'h1);
        chk("lit.reset nc.wr_ready",{31'h0, nc_ready},   32'h1);
        chk("lit.reset nc.pulse",   {31'h0, nc_pulse},   32'h0);
        chk("lit.reset nc.cc",      {16'h0, nc_cc},      32'h0);
        rst = 1'b0;

        // Test 1: 0 then 1 back-to-back, committed in order.
        drive(1'b1, 8'h00, 1'b1); tick();
        drive(1'b1, 8'h01, 1'b1); tick();
        chk("lit.t1 first out_q", {24'h0, nc_q},     32'h00);
        chk("lit.t1 first pulse", {31'h0, nc_pulse}, 32'h1);
        drive(1'b0, 8'h00, 1'b1); tick();
        chk("lit.t1 second out_q", {24'h0, nc_q},     32'h01);
        chk("lit.t1 second pulse", {31'h0, nc_pulse}, 32'h1);
        tick();
        chk("lit.t1 settled", {31'h0, nc_settled}, 32'h1);
        chk("lit.t1 cc",      {16'h0, nc_cc},      32'h2);

        // Test 2: fill with commit blocked, 5th refused, drain in order.
        do_reset();
        for (int i = 1; i <= 5; i++) begin
            drive(1'b1, 8'(i), 1'b0);
            if (i == 5) chk("lit.t2 full wr_ready", {31'h0, nc_ready}, 32'h0);
            tick();
        end
        drive(1'b0, 8'h00, 1'b1);
        for (int i = 1; i <= 4; i++) begin
            tick();
            chk("lit.t2 drain out_q", {24'h0, nc_q}, 32'(i));
        end
        tick();
        chk("lit.t2 settled", {31'h0, nc_settled}, 32'h1);
        chk("lit.t2 co coalesced", {16'h0, co_coal}, 32'h4);

        // Test 3: coalesce 0,1,0,1 into a single pending entry.
        do_reset();
        drive(1'b1, 8'h00, 1'b0); tick();
        drive(1'b1, 8'h01, 1'b0); tick();
        drive(1'b1, 8'h00, 1'b0); tick();
        drive(1'b1, 8'h01, 1'b0); tick();
        chk("lit.t3 coal_cnt", {16'h0, co_coal},    32'h3);
        chk("lit.t3 pending",  {31'h0, co_settled}, 32'h0);
        drive(1'b0, 8'h00, 1'b1); tick();
        chk("lit.t3 out_q", {24'h0, co_q},  32'h01);
        chk("lit.t3 cc",    {16'h0, co_cc}, 32'h1);
        tick();
        chk("lit.t3 settled", {31'h0, co_settled}, 32'h1);

        // Test 4: write arrives while the single entry is being popped.
        do_reset();
        drive(1'b1, 8'h07, 1'b0); tick();
        drive(1'b1, 8'h05, 1'b1); tick();
        chk("lit.t4 first out_q", {24'h0, co_q}, 32'h07);
        drive(1'b0, 8'h00, 1'b1); tick();
        chk("lit.t4 second out_q", {24'h0, co_q},     32'h05);
        chk("lit.t4 second pulse", {31'h0, co_pulse}, 32'h1);
        chk("lit.t4 coal_cnt",     {16'h0, co_coal},  32'h0);

        // Test 5: reset mid-cycle with pending writes.
        do_reset();
        drive(1'b1, 8'h09, 1'b1); tick();
        drive(1'b1, 8'h01, 1'b0); tick();
        drive(1'b1, 8'h02, 1'b0); tick();
        drive(1'b1, 8'h03, 1'b0); tick();
        drive(1'b0, 8'h00, 1'b0);
        rst = 1'b1;
        #1;
        chk("lit.t5 nc.out_q",   {24'h0, nc_q},       32'hA5);
        chk("lit.t5 co.out_q",   {24'h0, co_q},       32'h00);
        chk("lit.t5 nc.settled", {31'h0, nc_settled}, 32'h1);
        chk("lit.t5 co.settled", {31'h0, co_settled}, 32'h1);
        tick();
        rst = 1'b0;
        drive(1'b0, 8'h00, 1'b1);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("lit.t5 no pulse", {31'h0, nc_pulse}, 32'h0);
        end

        // Test 6: commit counter wrap.
        do_reset();
        for (int i = 0; i < 65535; i++) begin
            drive(1'b1, 8'(i), 1'b1);
            tick();
        end
        drive(1'b0, 8'h00, 1'b1); tick(); tick();
        chk("lit.t6 nc.cc max", {16'h0, nc_cc}, 32'hFFFF);
        drive(1'b1, 8'h3C, 1'b1); tick();
        drive(1'b0, 8'h00, 1'b1); tick(); tick();
        chk("lit.t6 nc.cc wrap",  {16'h0, nc_cc}, 32'h0);
        chk("lit.t6 co.cc wrap",  {16'h0, co_cc}, 32'h0);
        chk("lit.t6 nc.out_q",    {24'h0, nc_q},  32'h3C);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
